gfx_mem_arbiter: RTL

Four-way read arbiter that shares one 16-bit memory read port between the graphics fetch engines: sprite controller, background 0, background 1 and overlay. It sits between the gfx top level and the memory controller. The arbiter exposes one rvalid/rready read port per fetch engine and drives a single rvalid/rready port toward memory. Arbitration is round-robin. A requester that keeps requesting may hold its grant for up to MAX_BURST consecutive beats.

---
 rtl/gfx_mem_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/gfx_mem_arbiter.sv
// Four-way round-robin read arbiter in front of one 16-bit memory read port; grant and registered request 1 cycle after rvalid.
// The owner may keep the port for up to MAX_BURST beats; requesters hold rvalid and address until their rready pulse.
module gfx_mem_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int ADDR_BITS = 16
) (
  input  logic                 CLK,
  input  logic                 RSTb,
  input  logic [ADDR_BITS-1:0] spcon_memory_address,
  input  logic                 spcon_rvalid,
  output logic                 spcon_rready,
  output logic [15:0]          spcon_memory_data,
  input  logic [ADDR_BITS-1:0] bg0_memory_address,
  input  logic                 bg0_rvalid,
  output logic                 bg0_rready,
  output logic [15:0]          bg0_memory_data,
  input  logic [ADDR_BITS-1:0] bg1_memory_address,
  input  logic                 bg1_rvalid,
  output logic                 bg1_rready,
  output logic [15:0]          bg1_memory_data,
  input  logic [ADDR_BITS-1:0] ov_memory_address,
  input  logic                 ov_rvalid,
  output logic                 ov_rready,
  output logic [15:0]          ov_memory_data,
  output logic [ADDR_BITS-1:0] mem_address,
  output logic                 mem_rvalid,
  input  logic                 mem_rready,
  input  logic [15:0]          mem_data,
  output logic [1:0]           grant,
  output logic                 busy
);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  state_t               state_q, state_d;
  logic [1:0]           owner_q, owner_d;
  logic [1:0]           grant_q, grant_d;
  logic [3:0]           beat_cnt_q, beat_cnt_d;
  logic [ADDR_BITS-1:0] mem_address_q, mem_address_d;
  logic                 mem_rvalid_q, mem_rvalid_d;

  logic [3:0]           req;
  logic [ADDR_BITS-1:0] req_addr [4];
  logic [1:0]           pick;
  logic [1:0]           cand;
  logic                 found;
  logic                 keep_owner;

  assign req         = {ov_rvalid, bg1_rvalid, bg0_rvalid, spcon_rvalid};
  assign req_addr[0] = spcon_memory_address;
  assign req_addr[1] = bg0_memory_address;
  assign req_addr[2] = bg1_memory_address;
  assign req_addr[3] = ov_memory_address;

  // Search starts just after the owner and wraps back onto it last.
  always_comb begin
    pick  = owner_q;
    cand  = owner_q;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = owner_q + 2'(k);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // beat_cnt of zero only occurs out of reset, meaning nobody owns a burst yet.
  assign keep_owner = req[owner_q] && (beat_cnt_q != 4'd0) && (beat_cnt_q < BURST_LIM);

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    grant_d       = grant_q;
    beat_cnt_d    = beat_cnt_q;
    mem_address_d = mem_address_q;
    mem_rvalid_d  = mem_rvalid_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          if (keep_owner) begin
            beat_cnt_d    = beat_cnt_q + 4'd1;
            grant_d       = owner_q;
            mem_address_d = req_addr[owner_q];
          end else begin
            owner_d       = pick;
            beat_cnt_d    = 4'd1;
            grant_d       = pick;
            mem_address_d = req_addr[pick];
          end
          mem_rvalid_d = 1'b1;
          state_d      = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (mem_rready) begin
          mem_rvalid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q       <= ST_IDLE;
      owner_q       <= 2'd3;
      grant_q       <= 2'd0;
      beat_cnt_q    <= 4'd0;
      mem_address_q <= '0;
      mem_rvalid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      grant_q       <= grant_d;
      beat_cnt_q    <= beat_cnt_d;
      mem_address_q <= mem_address_d;
      mem_rvalid_q  <= mem_rvalid_d;
    end
  end

  assign busy        = (state_q == ST_GRANT);
  assign grant       = grant_q;
  assign mem_address = mem_address_q;
  assign mem_rvalid  = mem_rvalid_q;

  assign spcon_rready = mem_rready && busy && (grant_q == 2'd0);
  assign bg0_rready   = mem_rready && busy && (grant_q == 2'd1);
  assign bg1_rready   = mem_rready && busy && (grant_q == 2'd2);
  assign ov_rready    = mem_rready && busy && (grant_q == 2'd3);

  assign spcon_memory_data = mem_data;
  assign bg0_memory_data   = mem_data;
  assign bg1_memory_data   = mem_data;
  assign ov_memory_data    = mem_data;

endmodule
